// File: rtl/ps2_pkg.sv
// Shared PS/2 host-side types, command bytes and frame helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        WAIT_ACK,
        RELEASE,
        ERROR
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

    localparam int unsigned PS2_EDGE_W = 4;

    // Parity bit that makes the total count of ones across data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes raw PS/2 clock/data pads and flags falling edges of the clock.
// Shared with the keyboard receiver.
module ps2_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_pad_i,
    input  logic dat_pad_i,
    output logic clk_sync_o,
    output logic dat_sync_o,
    output logic fall_edge_c
);
    // Fewer than two stages is not metastability-safe, so clamp.
    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] clk_sync_q;
    logic [STAGES-1:0] dat_sync_q;
    logic              clk_prev_q;

    // Idle bus level is high, so reset the chains to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[STAGES-2:0], clk_pad_i};
            dat_sync_q <= {dat_sync_q[STAGES-2:0], dat_pad_i};
            clk_prev_q <= clk_sync_q[STAGES-1];
        end
    end

    assign clk_sync_o  = clk_sync_q[STAGES-1];
    assign dat_sync_o  = dat_sync_q[STAGES-1];
    assign fall_edge_c = clk_prev_q & ~clk_sync_q[STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data enables.
// Define PS2_TX_RETRY_EN to re-send a failed frame once before reporting txError.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       Clk,
    input  logic       Reset_N,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    input  logic       psClkIn,
    input  logic       psDataIn,
    output logic       psClkDrive,
    output logic       psDataDrive,
    output logic       busy,
    output logic       txDone,
    output logic       txError
);
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                         : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_DONE  = CNT_W'(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    ps2_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PS2_EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [7:0]            byte_q, byte_d;
    logic                  clk_drive_q, clk_drive_d;
    logic                  data_drive_q, data_drive_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  ready_q, busy_q;
    logic                  clk_sync, dat_sync, fall_edge;
`ifdef PS2_TX_RETRY_EN
    logic                  retry_q, retry_d;
`endif

    ps2_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (Clk),
        .rst_n       (Reset_N),
        .clk_pad_i   (psClkIn),
        .dat_pad_i   (psDataIn),
        .clk_sync_o  (clk_sync),
        .dat_sync_o  (dat_sync),
        .fall_edge_c (fall_edge)
    );

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            edge_cnt_q   <= '0;
            byte_q       <= '0;
            clk_drive_q  <= 1'b0;
            data_drive_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            byte_q       <= byte_d;
            clk_drive_q  <= clk_drive_d;
            data_drive_q <= data_drive_d;
            done_q       <= done_d;
            error_q      <= error_d;
            ready_q      <= (state_d == IDLE);
            busy_q       <= (state_d != IDLE);
`ifdef PS2_TX_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        edge_cnt_d   = edge_cnt_q;
        byte_d       = byte_q;
        clk_drive_d  = clk_drive_q;
        data_drive_d = data_drive_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d      = retry_q;
`endif

        unique case (state_q)
            IDLE: begin
                clk_drive_d  = 1'b0;
                data_drive_d = 1'b0;
                if (txValid && ready_q) begin
                    byte_d      = txData;
                    cnt_d       = '0;
                    edge_cnt_d  = '0;
                    clk_drive_d = 1'b1;
                    state_d     = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d     = 1'b0;
`endif
                end
            end
            // Hold clock low, then assert the start bit one cycle before release.
            INHIBIT: begin
                clk_drive_d  = 1'b1;
                data_drive_d = 1'b0;
                cnt_d        = cnt_q + CNT_ONE;
                if (cnt_q == INH_START) begin
                    data_drive_d = 1'b1;
                end else if (cnt_q == INH_DONE) begin
                    clk_drive_d  = 1'b0;
                    data_drive_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_edge) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (edge_cnt_q < 4'd8) begin
                        data_drive_d = ~byte_q[edge_cnt_q[2:0]];
                    end else if (edge_cnt_q == 4'd8) begin
                        data_drive_d = ~odd_parity(byte_q);
                    end else begin
                        data_drive_d = 1'b0;
                        state_d      = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (fall_edge) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (!dat_sync) begin
                        state_d = RELEASE;
                    end else begin
                        clk_drive_d  = 1'b0;
                        data_drive_d = 1'b0;
                        state_d      = ERROR;
                    end
                end
            end
            RELEASE: begin
                if (clk_sync && dat_sync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            ERROR: begin
                clk_drive_d  = 1'b0;
                data_drive_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
                if (!retry_q) begin
                    retry_d     = 1'b1;
                    cnt_d       = '0;
                    edge_cnt_d  = '0;
                    clk_drive_d = 1'b1;
                    state_d     = INHIBIT;
                end else begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
`else
                error_d = 1'b1;
                state_d = IDLE;
`endif
            end
            default: begin
                clk_drive_d  = 1'b0;
                data_drive_d = 1'b0;
                state_d      = IDLE;
            end
        endcase

        // Device-clock watchdog: restarts on every falling edge.
        if (state_q == SHIFT || state_q == WAIT_ACK || state_q == RELEASE) begin
            if (fall_edge) begin
                cnt_d = '0;
            end else if (cnt_q == TO_LAST && state_d == state_q) begin
                clk_drive_d  = 1'b0;
                data_drive_d = 1'b0;
                state_d      = ERROR;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign txReady     = ready_q;
    assign busy        = busy_q;
    assign psClkDrive  = clk_drive_q;
    assign psDataDrive = data_drive_q;
    assign txDone      = done_q;
    assign txError     = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on the open-drain lines plus a frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 5000;
    localparam int TOUT = 3000;
    localparam int SYNC = 2;
    localparam int H    = 20;

    logic       Clk = 1'b0;
    logic       Reset_N = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       txValid = 1'b0;
    logic       txReady, busy, txDone, txError, psClkDrive, psDataDrive;
    logic       psClkIn, psDataIn;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    assign psClkIn  = ~(psClkDrive | dev_clk_low);
    assign psDataIn = ~(psDataDrive | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TOUT),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .Clk         (Clk),
        .Reset_N     (Reset_N),
        .txData      (txData),
        .txValid     (txValid),
        .txReady     (txReady),
        .psClkIn     (psClkIn),
        .psDataIn    (psDataIn),
        .psClkDrive  (psClkDrive),
        .psDataDrive (psDataDrive),
        .busy        (busy),
        .txDone      (txDone),
        .txError     (txError)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected 10-bit frame as seen on the data line: {stop, parity, data LSB-first}.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0), b};
    endfunction

    // Device behaviour knobs and observations.
    int          nak_count = 0;
    int          stop_after = 0;
    int          pulse_cnt = 11;
    int          frames_seen = 0;
    int          last_fall_cyc = 0;
    logic        dev_active = 1'b0;
    logic [9:0]  rx_q[$];

    // Bus observations.
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int inh_run = 0;
    int st_run = 0;
    int inh_q[$];
    int st_q[$];

    always @(negedge Clk) begin
        cyc++;
        if (!Reset_N) begin
            inh_run = 0;
            st_run  = 0;
        end else begin
            if (txDone) done_cnt++;
            if (txError) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (psClkDrive && !psDataDrive) inh_run++;
            else if (psClkDrive && psDataDrive) st_run++;
            else if (inh_run != 0 || st_run != 0) begin
                inh_q.push_back(inh_run);
                st_q.push_back(st_run);
                inh_run = 0;
                st_run  = 0;
            end
        end
    end

    // Per-cycle invariants derived from the protocol rules.
    always @(negedge Clk) begin
        if (Reset_N) begin
            check("ready_is_not_busy", 32'(txReady), 32'(!busy));
            check("done_error_exclusive", 32'(txDone & txError), 32'd0);
            if (!busy) check("idle_lines_released", 32'({psClkDrive, psDataDrive}), 32'd0);
            if (dev_active) check("host_clk_released_while_device_clocks", 32'(psClkDrive), 32'd0);
        end
    end

    // Behavioural PS/2 device: answers a request-to-send with up to 11 clock pulses.
    initial begin : device
        logic [9:0] bits;
        logic       nak;
        int         p;
        forever begin
            @(negedge Clk);
            if (Reset_N && psDataDrive && !psClkDrive) begin
                frames_seen++;
                pulse_cnt  = 0;
                nak        = (nak_count > 0);
                if (nak) nak_count--;
                dev_active = 1'b1;
                bits       = '0;
                repeat (10) @(negedge Clk);
                p = 1;
                while (p <= 11 && (stop_after == 0 || p <= stop_after)) begin
                    if (p == 11 && !nak) begin
                        dev_dat_low = 1'b1;
                        repeat (4) @(negedge Clk);
                    end
                    dev_clk_low   = 1'b1;
                    pulse_cnt     = p;
                    last_fall_cyc = cyc;
                    repeat (H) @(negedge Clk);
                    if (p <= 10) bits[p-1] = psDataIn;
                    dev_clk_low = 1'b0;
                    if (p == 11 || p == stop_after) dev_active = 1'b0;
                    repeat (H) @(negedge Clk);
                    dev_dat_low = 1'b0;
                    p++;
                end
                dev_active = 1'b0;
                if (p == 12) rx_q.push_back(bits);
                while (psDataDrive && !psClkDrive) @(negedge Clk);
            end
        end
    end

    initial begin : watchdog
        repeat (95000) @(negedge Clk);
        $display("FAIL watchdog cycle budget expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        @(negedge Clk);
        txData  = b;
        txValid = 1'b1;
        @(negedge Clk);
        txValid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input int exp_frames,
                             input int exp_done, input int exp_err);
        int d0, e0, f0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        f0 = frames_seen;
        send(b);
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 30000) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_finished_in_time"}, 32'(n < 30000), 32'd1);
        repeat (200) @(negedge Clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(exp_done));
        check({tag, "_error_pulses"}, 32'(err_cnt - e0), 32'(exp_err));
        check({tag, "_frames_on_bus"}, 32'(frames_seen - f0), 32'(exp_frames));
        check({tag, "_ready_after"}, 32'(txReady), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic check_frames(input string tag, input logic [7:0] b, input int n_rx, input int n_inh);
        check({tag, "_rx_frames"}, 32'(rx_q.size()), 32'(n_rx));
        check({tag, "_inhibit_phases"}, 32'(inh_q.size()), 32'(n_inh));
        while (rx_q.size() > 0) check({tag, "_frame_bits"}, 32'(rx_q.pop_front()), 32'(model_frame(b)));
        while (inh_q.size() > 0) begin
            check({tag, "_inhibit_len"}, 32'(inh_q.pop_front()), 32'(INH));
            check({tag, "_start_len"}, 32'(st_q.pop_front()), 32'd1);
        end
    endtask

    task automatic clear_obs();
        rx_q.delete();
        inh_q.delete();
        st_q.delete();
    endtask

    initial begin : stimulus
        int d;
        int n;
        int d0, e0;

        repeat (5) @(negedge Clk);
        check("reset_ready", 32'(txReady), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_clk_drive", 32'(psClkDrive), 32'd0);
        check("reset_data_drive", 32'(psDataDrive), 32'd0);
        check("reset_done", 32'(txDone), 32'd0);
        check("reset_error", 32'(txError), 32'd0);
        Reset_N = 1'b1;
        repeat (5) @(negedge Clk);

        // Enable command, acknowledged.
        clear_obs();
        run_frame("f4_ack", 8'hF4, 1, 1, 0);
        if (rx_q.size() > 0) begin
            check("f4_data_bits_literal", 32'(rx_q[0][7:0]), 32'h0F4);
            check("f4_parity_literal", 32'(rx_q[0][8]), 32'd0);
            check("f4_stop_literal", 32'(rx_q[0][9]), 32'd1);
        end
        check_frames("f4_ack", 8'hF4, 1, 1);

        // Set-LEDs command with a second request while busy that must be dropped.
        clear_obs();
        fork
            run_frame("ed_ack", 8'hED, 1, 1, 0);
            begin
                n = 0;
                while (pulse_cnt != 4 && n < 20000) begin
                    @(negedge Clk);
                    n++;
                end
                check("ed_reached_edge4", 32'(n < 20000), 32'd1);
                txData  = 8'hFF;
                txValid = 1'b1;
                @(negedge Clk);
                txValid = 1'b0;
            end
        join
        if (rx_q.size() > 0) begin
            check("ed_parity_literal", 32'(rx_q[0][8]), 32'd1);
            check("ed_frame_literal", 32'(rx_q[0]), 32'h3ED);
        end
        check_frames("ed_ack", 8'hED, 1, 1);

        // Device never acknowledges.
        clear_obs();
`ifdef PS2_TX_RETRY_EN
        nak_count = 2;
        run_frame("ff_nak", 8'hFF, 2, 0, 1);
        check_frames("ff_nak", 8'hFF, 2, 2);
`else
        nak_count = 1;
        run_frame("ff_nak", 8'hFF, 1, 0, 1);
        check_frames("ff_nak", 8'hFF, 1, 1);
`endif
        check("ff_nak_clk_released", 32'(psClkDrive), 32'd0);
        check("ff_nak_data_released", 32'(psDataDrive), 32'd0);

        // Device stops clocking after edge 3.
        clear_obs();
        stop_after = 3;
`ifdef PS2_TX_RETRY_EN
        run_frame("timeout", 8'hF4, 2, 0, 1);
        check_frames("timeout", 8'hF4, 0, 2);
`else
        run_frame("timeout", 8'hF4, 1, 0, 1);
        check_frames("timeout", 8'hF4, 0, 1);
`endif
        stop_after = 0;
        d = err_cyc - last_fall_cyc;
        checks++;
        if (d < TOUT || d > TOUT + SYNC + 4) begin
            errors++;
            $display("FAIL timeout_latency actual=%0d expected=%0d..%0d", d, TOUT, TOUT + SYNC + 4);
        end

`ifdef PS2_TX_RETRY_EN
        // One refusal then acceptance: retry succeeds silently.
        clear_obs();
        nak_count = 1;
        run_frame("retry_ok", 8'hED, 2, 1, 0);
        check_frames("retry_ok", 8'hED, 2, 2);
`endif

        // Asynchronous reset in the middle of the data bits.
        clear_obs();
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hF4);
        n = 0;
        while (pulse_cnt != 5 && n < 20000) begin
            @(negedge Clk);
            n++;
        end
        check("midreset_reached_edge5", 32'(n < 20000), 32'd1);
        repeat (2) @(negedge Clk);
        #2 Reset_N = 1'b0;
        #1;
        check("midreset_clk_drive", 32'(psClkDrive), 32'd0);
        check("midreset_data_drive", 32'(psDataDrive), 32'd0);
        check("midreset_ready", 32'(txReady), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge Clk);
        Reset_N = 1'b1;
        n = 0;
        while (dev_active && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        repeat (100) @(negedge Clk);
        check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
        check("midreset_no_error", 32'(err_cnt - e0), 32'd0);
        clear_obs();

        // Recovery after reset.
        run_frame("recover_ed", 8'hED, 1, 1, 0);
        check_frames("recover_ed", 8'hED, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
